// File: rtl/mem_issue_queue.sv
// In-order issue queue for memory instructions feeding the AGU.
// Entries wait for both source operands, woken by two result-broadcast lanes,
// and issue strictly from the head in program order.
module mem_issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OP_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  // Dispatch
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [OP_W-1:0]        disp_op,
  input  logic [15:0]            disp_imm,
  input  logic [3:0]             disp_rob_entry_num,
  input  logic [5:0]             disp_phy_dest,
  input  logic [5:0]             disp_src1_tag,
  input  logic [5:0]             disp_src2_tag,
  input  logic                   disp_src1_rdy,
  input  logic                   disp_src2_rdy,
  input  logic [31:0]            disp_src1_value,
  input  logic [31:0]            disp_src2_value,
  // Result broadcast
  input  logic [1:0]             wb_valid,
  input  logic [1:0][5:0]        wb_tag,
  input  logic [1:0][31:0]       wb_value,
  // Issue to AGU
  output logic                   issue_to_agu_valid,
  input  logic                   agu_allowin,
  output logic [OP_W-1:0]        issue_op,
  output logic [15:0]            issue_imm,
  output logic [3:0]             issue_rob_entry_num,
  output logic [5:0]             issue_phy_dest,
  output logic [31:0]            issue_src1_value,
  output logic [31:0]            issue_src2_value,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Control state (reset)
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;
  logic [DEPTH-1:0] valid_q, s1_rdy_q, s2_rdy_q;

  // Payload state (not reset)
  logic [OP_W-1:0] op_q      [DEPTH];
  logic [15:0]     imm_q     [DEPTH];
  logic [3:0]      rob_q     [DEPTH];
  logic [5:0]      dest_q    [DEPTH];
  logic [5:0]      s1_tag_q  [DEPTH];
  logic [5:0]      s2_tag_q  [DEPTH];
  logic [31:0]     s1_val_q  [DEPTH];
  logic [31:0]     s2_val_q  [DEPTH];

  // Wakeup results per stored entry and for the entry being dispatched
  logic [DEPTH-1:0] s1_wake, s2_wake;
  logic [31:0]      s1_wval [DEPTH];
  logic [31:0]      s2_wval [DEPTH];
  logic [32:0]      enq_s1_m, enq_s2_m;

  logic enq, deq;

  // Returns {hit, value}; lane 1 wins when both lanes match, tag 0 never matches.
  function automatic logic [32:0] wb_match(input logic [5:0]       tag,
                                           input logic [1:0]       v,
                                           input logic [1:0][5:0]  t,
                                           input logic [1:0][31:0] val);
    logic [32:0] res;
    res = '0;
    if (tag != 6'd0) begin
      if (v[1] && (t[1] == tag)) begin
        res = {1'b1, val[1]};
      end else if (v[0] && (t[0] == tag)) begin
        res = {1'b1, val[0]};
      end
    end
    return res;
  endfunction

  assign disp_ready         = (count_q != CntW'(DEPTH));
  assign enq                = disp_valid && disp_ready && !flush;
  assign issue_to_agu_valid = (count_q != '0) && s1_rdy_q[head_q] && s2_rdy_q[head_q] && !flush;
  assign deq                = issue_to_agu_valid && agu_allowin;

  assign issue_op            = op_q[head_q];
  assign issue_imm           = imm_q[head_q];
  assign issue_rob_entry_num = rob_q[head_q];
  assign issue_phy_dest      = dest_q[head_q];
  assign issue_src1_value    = s1_val_q[head_q];
  assign issue_src2_value    = s2_val_q[head_q];
  assign queue_count         = count_q;

  // Broadcast tag match for every waiting operand and for the incoming entry
  always_comb begin
    logic [32:0] m1, m2;
    s1_wake = '0;
    s2_wake = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m1 = wb_match(s1_tag_q[i], wb_valid, wb_tag, wb_value);
      m2 = wb_match(s2_tag_q[i], wb_valid, wb_tag, wb_value);
      s1_wake[i] = valid_q[i] && !s1_rdy_q[i] && m1[32];
      s2_wake[i] = valid_q[i] && !s2_rdy_q[i] && m2[32];
      s1_wval[i] = m1[31:0];
      s2_wval[i] = m2[31:0];
    end
    enq_s1_m = wb_match(disp_src1_tag, wb_valid, wb_tag, wb_value);
    enq_s2_m = wb_match(disp_src2_tag, wb_valid, wb_tag, wb_value);
  end

  // Pointers, occupancy and per-entry valid/ready bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
    end else if (flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (s1_wake[i]) s1_rdy_q[i] <= 1'b1;
        if (s2_wake[i]) s2_rdy_q[i] <= 1'b1;
      end
      // Tail slot is never valid when enq is allowed, so no clash with wakeup above
      if (enq) begin
        valid_q[tail_q]  <= 1'b1;
        s1_rdy_q[tail_q] <= disp_src1_rdy || enq_s1_m[32];
        s2_rdy_q[tail_q] <= disp_src2_rdy || enq_s2_m[32];
        tail_q           <= tail_q + PtrW'(1);
      end
      if (deq) begin
        valid_q[head_q]  <= 1'b0;
        s1_rdy_q[head_q] <= 1'b0;
        s2_rdy_q[head_q] <= 1'b0;
        head_q           <= head_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload write on enqueue and operand capture on wakeup
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (s1_wake[i]) s1_val_q[i] <= s1_wval[i];
      if (s2_wake[i]) s2_val_q[i] <= s2_wval[i];
    end
    if (enq) begin
      op_q[tail_q]     <= disp_op;
      imm_q[tail_q]    <= disp_imm;
      rob_q[tail_q]    <= disp_rob_entry_num;
      dest_q[tail_q]   <= disp_phy_dest;
      s1_tag_q[tail_q] <= disp_src1_tag;
      s2_tag_q[tail_q] <= disp_src2_tag;
      s1_val_q[tail_q] <= disp_src1_rdy ? disp_src1_value : enq_s1_m[31:0];
      s2_val_q[tail_q] <= disp_src2_rdy ? disp_src2_value : enq_s2_m[31:0];
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Scoreboard bench for mem_issue_queue: accepted dispatches are pushed with
// their expected final operand values and popped when the AGU takes an entry.
module tb_mem_issue_queue;

  localparam int DEPTH = 8;
  localparam int OP_W  = 8;

  logic             clk, reset, flush;
  logic             disp_valid, disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [15:0]      disp_imm;
  logic [3:0]       disp_rob_entry_num;
  logic [5:0]       disp_phy_dest, disp_src1_tag, disp_src2_tag;
  logic             disp_src1_rdy, disp_src2_rdy;
  logic [31:0]      disp_src1_value, disp_src2_value;
  logic [1:0]       wb_valid;
  logic [1:0][5:0]  wb_tag;
  logic [1:0][31:0] wb_value;
  logic             issue_to_agu_valid, agu_allowin;
  logic [OP_W-1:0]  issue_op;
  logic [15:0]      issue_imm;
  logic [3:0]       issue_rob_entry_num;
  logic [5:0]       issue_phy_dest;
  logic [31:0]      issue_src1_value, issue_src2_value;
  logic [3:0]       queue_count;

  mem_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .disp_valid          (disp_valid),
    .disp_ready          (disp_ready),
    .disp_op             (disp_op),
    .disp_imm            (disp_imm),
    .disp_rob_entry_num  (disp_rob_entry_num),
    .disp_phy_dest       (disp_phy_dest),
    .disp_src1_tag       (disp_src1_tag),
    .disp_src2_tag       (disp_src2_tag),
    .disp_src1_rdy       (disp_src1_rdy),
    .disp_src2_rdy       (disp_src2_rdy),
    .disp_src1_value     (disp_src1_value),
    .disp_src2_value     (disp_src2_value),
    .wb_valid            (wb_valid),
    .wb_tag              (wb_tag),
    .wb_value            (wb_value),
    .issue_to_agu_valid  (issue_to_agu_valid),
    .agu_allowin         (agu_allowin),
    .issue_op            (issue_op),
    .issue_imm           (issue_imm),
    .issue_rob_entry_num (issue_rob_entry_num),
    .issue_phy_dest      (issue_phy_dest),
    .issue_src1_value    (issue_src1_value),
    .issue_src2_value    (issue_src2_value),
    .queue_count         (queue_count)
  );

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [15:0]     imm;
    logic [3:0]      rob;
    logic [5:0]      dest;
    logic [31:0]     s1;
    logic [31:0]     s2;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] exp_s1, exp_s2;
  int          vectors = 0;
  int          miscompares = 0;
  logic        model_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      model_ready = (sb.size() != DEPTH);
      vectors++;
      if (queue_count !== 4'(sb.size())) begin
        miscompares++;
        $display("FAIL queue_count: got %0d expected %0d", queue_count, sb.size());
      end
      vectors++;
      if (disp_ready !== model_ready) begin
        miscompares++;
        $display("FAIL disp_ready: got %b expected %b", disp_ready, model_ready);
      end
      if (issue_to_agu_valid === 1'b1 && agu_allowin) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected: op %h issued with empty scoreboard", issue_op);
        end else begin
          got = '{issue_op, issue_imm, issue_rob_entry_num, issue_phy_dest,
                  issue_src1_value, issue_src2_value};
          if (got !== sb[0]) begin
            miscompares++;
            $display("FAIL issue_payload: got %h expected %h", got, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
      if (disp_valid && model_ready && !flush) begin
        sb.push_back('{disp_op, disp_imm, disp_rob_entry_num, disp_phy_dest, exp_s1, exp_s2});
      end
      if (flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // v1/v2 are the values the entry must finally issue with
  task automatic set_disp(input logic [7:0] op,
                          input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                          input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    disp_valid         = 1'b1;
    disp_op            = op;
    disp_imm           = {8'h5A, op};
    disp_rob_entry_num = op[3:0];
    disp_phy_dest      = op[5:0] + 6'd1;
    disp_src1_tag      = t1;
    disp_src2_tag      = t2;
    disp_src1_rdy      = r1;
    disp_src2_rdy      = r2;
    disp_src1_value    = r1 ? v1 : 32'hBADBAD00;
    disp_src2_value    = r2 ? v2 : 32'hBADBAD00;
    exp_s1             = v1;
    exp_s2             = v2;
  endtask

  task automatic clr_disp();
    disp_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got_b, input logic exp_b);
    vectors++;
    if (got_b !== exp_b) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got_b, exp_b);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int c = 0; c < 40 && sb.size() != 0; c++) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d entries still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    check_bit("reset_disp_ready", disp_ready, 1'b1);
    check_bit("reset_issue_valid", issue_to_agu_valid, 1'b0);
    vectors++;
    if (queue_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", queue_count);
    end
    reset = 1'b0;
    step();
    check_bit("post_reset_disp_ready", disp_ready, 1'b1);
  endtask

  task automatic test_fill();
    agu_allowin = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(8'h10 + 8'(i), 6'd0, 1'b1, 32'h100 + i, 6'd0, 1'b1, 32'h200 + i);
      step();
    end
    set_disp(8'h18, 6'd0, 1'b1, 32'h108, 6'd0, 1'b1, 32'h208);
    check_bit("fill_disp_ready", disp_ready, 1'b0);
    vectors++;
    if (queue_count !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_count: got %0d expected 8", queue_count);
    end
    step();
    clr_disp();
    vectors++;
    if (queue_count !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_ninth_rejected: got count %0d expected 8", queue_count);
    end
    agu_allowin = 1'b1;
    wait_empty("fill");
  endtask

  task automatic test_wakeup();
    agu_allowin = 1'b1;
    set_disp(8'h21, 6'd5, 1'b0, 32'h1234, 6'd0, 1'b1, 32'h55);
    step();
    clr_disp();
    check_bit("wake_wait_valid", issue_to_agu_valid, 1'b0);
    step();
    wb_valid = 2'b01; wb_tag[0] = 6'd5; wb_value[0] = 32'h1234;
    check_bit("wake_capture_cycle_valid", issue_to_agu_valid, 1'b0);
    step();
    wb_valid = 2'b00;
    check_bit("wake_next_valid", issue_to_agu_valid, 1'b1);
    vectors++;
    if (issue_src1_value !== 32'h1234) begin
      miscompares++;
      $display("FAIL wake_src1: got %h expected 00001234", issue_src1_value);
    end
    wait_empty("wake");
  endtask

  task automatic test_same_cycle_wake();
    agu_allowin = 1'b1;
    set_disp(8'h22, 6'd0, 1'b1, 32'h77, 6'd9, 1'b0, 32'hDEAD);
    wb_valid = 2'b10; wb_tag[1] = 6'd9; wb_value[1] = 32'hDEAD;
    step();
    clr_disp();
    wb_valid = 2'b00;
    check_bit("same_cycle_valid", issue_to_agu_valid, 1'b1);
    vectors++;
    if (issue_src2_value !== 32'hDEAD) begin
      miscompares++;
      $display("FAIL same_cycle_src2: got %h expected 0000dead", issue_src2_value);
    end
    wait_empty("same_cycle");
  endtask

  task automatic test_lane_priority();
    agu_allowin = 1'b1;
    set_disp(8'h23, 6'd7, 1'b0, 32'hB0B0_0001, 6'd7, 1'b0, 32'hB0B0_0001);
    step();
    clr_disp();
    step();
    wb_valid = 2'b11;
    wb_tag[0] = 6'd7; wb_value[0] = 32'hA0A0_0000;
    wb_tag[1] = 6'd7; wb_value[1] = 32'hB0B0_0001;
    step();
    wb_valid = 2'b00;
    check_bit("prio_valid", issue_to_agu_valid, 1'b1);
    wait_empty("prio");
  endtask

  task automatic test_tag0();
    agu_allowin = 1'b0;
    set_disp(8'h24, 6'd0, 1'b1, 32'hC0DE_0000, 6'd0, 1'b1, 32'hC0DE_0001);
    wb_valid = 2'b11;
    wb_tag[0] = 6'd0; wb_value[0] = 32'hFFFF_0000;
    wb_tag[1] = 6'd0; wb_value[1] = 32'hFFFF_0001;
    step();
    clr_disp();
    step();
    wb_valid = 2'b00;
    agu_allowin = 1'b1;
    wait_empty("tag0");
  endtask

  task automatic test_order();
    agu_allowin = 1'b1;
    set_disp(8'h31, 6'd12, 1'b0, 32'h1200, 6'd0, 1'b1, 32'h1);
    step();
    set_disp(8'h32, 6'd0, 1'b1, 32'h3200, 6'd0, 1'b1, 32'h2);
    step();
    clr_disp();
    for (int c = 0; c < 3; c++) begin
      check_bit("order_blocked", issue_to_agu_valid, 1'b0);
      step();
    end
    wb_valid = 2'b01; wb_tag[0] = 6'd12; wb_value[0] = 32'h1200;
    step();
    wb_valid = 2'b00;
    vectors++;
    if (issue_op !== 8'h31) begin
      miscompares++;
      $display("FAIL order_head_op: got %h expected 31", issue_op);
    end
    wait_empty("order");
  endtask

  task automatic test_stream();
    agu_allowin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_disp(8'h40 + 8'(i), 6'd0, 1'b1, 32'h4000 + i, 6'd0, 1'b1, 32'h5000 + i);
      step();
      vectors++;
      if (queue_count !== 4'd1) begin
        miscompares++;
        $display("FAIL stream_count[%0d]: got %0d expected 1", i, queue_count);
      end
    end
    clr_disp();
    wait_empty("stream");
  endtask

  task automatic test_flush();
    agu_allowin = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(8'h50 + 8'(i), 6'd0, 1'b1, 32'h500 + i, 6'd0, 1'b1, 32'h600 + i);
      step();
    end
    set_disp(8'h60, 6'd0, 1'b1, 32'h60, 6'd0, 1'b1, 32'h61);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clr_disp();
    vectors++;
    if (queue_count !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_count: got %0d expected 0", queue_count);
    end
    check_bit("flush_disp_ready", disp_ready, 1'b1);
    check_bit("flush_issue_valid", issue_to_agu_valid, 1'b0);
    set_disp(8'h61, 6'd0, 1'b1, 32'h610, 6'd0, 1'b1, 32'h611);
    agu_allowin = 1'b1;
    step();
    clr_disp();
    wait_empty("flush");
  endtask

  task automatic test_async_reset();
    agu_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(8'h70 + 8'(i), 6'd0, 1'b1, 32'h700 + i, 6'd0, 1'b1, 32'h800 + i);
      step();
    end
    clr_disp();
    reset = 1'b1;
    agu_allowin = 1'b1;
    #1;
    vectors++;
    if (queue_count !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset_count: got %0d expected 0", queue_count);
    end
    check_bit("async_reset_issue_valid", issue_to_agu_valid, 1'b0);
    step();
    reset = 1'b0;
    step();
    check_bit("async_reset_after_ready", disp_ready, 1'b1);
    check_bit("async_reset_after_valid", issue_to_agu_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; agu_allowin = 1'b0;
    disp_valid = 1'b0; disp_op = '0; disp_imm = '0; disp_rob_entry_num = '0;
    disp_phy_dest = '0; disp_src1_tag = '0; disp_src2_tag = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    disp_src1_value = '0; disp_src2_value = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0;
    exp_s1 = '0; exp_s2 = '0;
    test_reset();
    test_fill();
    test_wakeup();
    test_same_cycle_wake();
    test_lane_priority();
    test_tag0();
    test_order();
    test_stream();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
